// File: rtl/xsm_event_logger.sv
// xsm_event_logger: turns each rising edge of the capture stage's sample_valid
// level into a timestamped record {seq, timestamp, sample}. Records are buffered
// in a show-ahead circular FIFO and drained over a valid/ready stream.
// Overflow is reported through a sticky flag and a saturating drop counter.
//
// Build option: define XSM_LOG_SEQ_EN to populate the 16-bit sequence field.
// Without it the field reads 16'h0 and no sequence register is built.
//
// Handshake: a record transfers on any cycle where rec_valid && rec_ready.
// rec_valid never depends on rec_ready, and rec_data stays stable while
// rec_valid is high and rec_ready is low.
//
// DEPTH must be a power of two and at least 2. AW is derived from it and
// should not be overridden.

module xsm_event_logger #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int DEPTH        = 16,
   parameter int AW           = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         log_en,
   input  logic                         clear,
   input  logic [47:0]                  mono_counter,
   input  logic [SAMPLE_WIDTH-1:0]      sample_data,
   input  logic                         sample_valid,
   output logic                         rec_valid,
   input  logic                         rec_ready,
   output logic [64+SAMPLE_WIDTH-1:0]   rec_data,
   output logic [AW:0]                  fifo_level,
   output logic                         overflow,
   output logic [15:0]                  drop_count
);

   localparam int RW = 64 + SAMPLE_WIDTH;

   // Edge detector state
   logic          sv_q;

   // FIFO storage and pointers; the extra MSB separates full from empty
   logic [RW-1:0] mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;

   // Loss tracking
   logic          overflow_q, overflow_d;
   logic [15:0]   drop_count_q, drop_count_d;

   // Per-cycle decode
   logic          fifo_empty;
   logic          fifo_full;
   logic          evt;
   logic          pop;
   logic          push;
   logic          drop;
   logic [15:0]   seq_field;
   logic [RW-1:0] new_rec;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A held-high level produces one event; log_en gates everything downstream
   assign evt  = sample_valid && !sv_q && log_en;
   assign pop  = !fifo_empty && rec_ready && !clear;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept
   assign push = evt && !clear && (!fifo_full || pop);
   assign drop = evt && !clear && fifo_full && !pop;

   assign new_rec = {seq_field, mono_counter, sample_data};

`ifdef XSM_LOG_SEQ_EN
   logic [15:0] seq_q, seq_d;

   // Sequence advances on every event, stored or dropped, and wraps at 16 bits
   always_comb begin
      seq_d = seq_q;
      if (clear) begin
         seq_d = 16'h0;
      end else if (evt) begin
         seq_d = seq_q + 16'h1;
      end
   end

   // Sequence register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_q <= 16'h0;
      end else begin
         seq_q <= seq_d;
      end
   end

   assign seq_field = seq_q;
`else
   assign seq_field = 16'h0;
`endif

   // Pointer and loss-tracking next state; clear overrides push, pop and drop
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      if (clear) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         overflow_d   = 1'b0;
         drop_count_d = 16'h0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
               drop_count_d = drop_count_q + 16'h1;
            end
         end
      end
   end

   // Control registers; async reset discards all records at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sv_q         <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= 16'h0;
      end else begin
         sv_q         <= sample_valid;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Record storage; contents need no reset because the pointers gate visibility
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= new_rec;
      end
   end

   assign rec_valid  = !fifo_empty;
   // Forced to zero while empty so the reset value is defined without a clock
   assign rec_data   = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign fifo_level = wr_ptr_q - rd_ptr_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_xsm_event_logger.sv
// Bench for xsm_event_logger: directed stimulus, a queue-based reference model
// updated on every clock, a per-cycle compare process, and literal spot checks.

module tb_xsm_event_logger;

   localparam int SW    = 16;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);
   localparam int RW    = 64 + SW;

`ifdef XSM_LOG_SEQ_EN
   localparam bit SEQ_EN = 1'b1;
`else
   localparam bit SEQ_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst_n;
   logic          log_en;
   logic          clear;
   logic [47:0]   mono_counter;
   logic [SW-1:0] sample_data;
   logic          sample_valid;
   logic          rec_valid;
   logic          rec_ready;
   logic [RW-1:0] rec_data;
   logic [AW:0]   fifo_level;
   logic          overflow;
   logic [15:0]   drop_count;

   always #5 clk = ~clk;

   xsm_event_logger #(
      .SAMPLE_WIDTH (SW),
      .DEPTH        (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .log_en       (log_en),
      .clear        (clear),
      .mono_counter (mono_counter),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .rec_valid    (rec_valid),
      .rec_ready    (rec_ready),
      .rec_data     (rec_data),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .drop_count   (drop_count)
   );

   // ---------------- scoreboard state ----------------
   int            tests_run = 0;
   int            failures  = 0;
   logic [RW-1:0] exp_q[$];
   int            m_seq;
   bit            m_ov;
   int            m_drop;
   bit            m_sv;

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] exp_seq(input int n);
      return SEQ_EN ? 16'(n) : 16'h0;
   endfunction

   // Reference model: an event is a 0->1 of sample_valid with log_en high;
   // it is stored if there is room (counting a same-cycle pop), else counted lost
   initial begin
      exp_q.delete();
      m_seq = 0; m_ov = 0; m_drop = 0; m_sv = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            exp_q.delete();
            m_seq = 0; m_ov = 0; m_drop = 0; m_sv = 0;
         end else begin
            bit ev;
            bit did_pop;
            ev = sample_valid && !m_sv && log_en;
            if (clear) begin
               exp_q.delete();
               m_seq = 0; m_ov = 0; m_drop = 0;
            end else begin
               did_pop = (exp_q.size() > 0) && rec_ready;
               if (ev && (exp_q.size() < DEPTH || did_pop)) begin
                  if (did_pop) void'(exp_q.pop_front());
                  exp_q.push_back({exp_seq(m_seq), mono_counter, sample_data});
               end else begin
                  if (did_pop) void'(exp_q.pop_front());
                  if (ev) begin
                     m_ov = 1;
                     if (m_drop < 65535) m_drop++;
                  end
               end
               if (ev) m_seq = (m_seq + 1) % 65536;
            end
            m_sv = sample_valid;
         end
      end
   end

   // Compare process: outputs settle shortly after each rising edge
   always @(posedge clk) begin
      #1;
      check("rec_valid", RW'(rec_valid), RW'(exp_q.size() > 0));
      check("fifo_level", RW'(fifo_level), RW'(exp_q.size()));
      check("overflow", RW'(overflow), RW'(m_ov));
      check("drop_count", RW'(drop_count), RW'(m_drop));
      if (exp_q.size() > 0) check("rec_data", rec_data, exp_q[0]);
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      mono_counter = mono_counter + 48'h1;
   endtask

   task automatic pulse(input logic [SW-1:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      step();
      sample_valid = 1'b0;
      step();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n        = 1'b0;
      log_en       = 1'b0;
      clear        = 1'b0;
      mono_counter = 48'h0;
      sample_data  = '0;
      sample_valid = 1'b0;
      rec_ready    = 1'b0;
      repeat (2) step();

      // Reset values
      check("rst_rec_valid", RW'(rec_valid), RW'(0));
      check("rst_rec_data", rec_data, RW'(0));
      check("rst_fifo_level", RW'(fifo_level), RW'(0));
      check("rst_overflow", RW'(overflow), RW'(0));
      check("rst_drop_count", RW'(drop_count), RW'(0));
      rst_n  = 1'b1;
      log_en = 1'b1;
      step();

      // Single event, visible one cycle later
      mono_counter = 48'h100;
      sample_data  = 16'h1234;
      sample_valid = 1'b1;
      step();
      check("single_valid", RW'(rec_valid), RW'(1));
      check("single_data", rec_data, {16'h0000, 48'h000000000100, 16'h1234});
      sample_valid = 1'b0;
      rec_ready    = 1'b1;
      step();
      rec_ready = 1'b0;
      check("single_drained", RW'(fifo_level), RW'(0));

      // Held level: one record per rising edge
      clear = 1'b1; step(); clear = 1'b0;
      sample_valid = 1'b1; sample_data = 16'h5A5A;
      repeat (50) step();
      sample_valid = 1'b0; step();
      sample_valid = 1'b1; sample_data = 16'h6B6B; step();
      sample_valid = 1'b0; step();
      check("held_level", RW'(fifo_level), RW'(2));
      check("held_seq0", RW'(rec_data[RW-1:RW-16]), RW'(exp_seq(0)));
      rec_ready = 1'b1; step();
      check("held_seq1", RW'(rec_data[RW-1:RW-16]), RW'(exp_seq(1)));
      step(); rec_ready = 1'b0;
      check("held_empty", RW'(fifo_level), RW'(0));

      // Overflow: 20 events into a 16-deep FIFO
      clear = 1'b1; step(); clear = 1'b0;
      for (int i = 0; i < 20; i++) pulse(16'hA000 + 16'(i));
      check("ovf_level", RW'(fifo_level), RW'(16));
      check("ovf_flag", RW'(overflow), RW'(1));
      check("ovf_drops", RW'(drop_count), RW'(4));
      rec_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("ovf_drain_seq", RW'(rec_data[RW-1:RW-16]), RW'(exp_seq(i)));
         step();
      end
      rec_ready = 1'b0;
      check("ovf_drained", RW'(fifo_level), RW'(0));
      pulse(16'hA0FF);
      check("ovf_next_seq", RW'(rec_data[RW-1:RW-16]), RW'(exp_seq(20)));
      check("ovf_sticky", RW'(overflow), RW'(1));
      check("ovf_drops_hold", RW'(drop_count), RW'(4));

      // Full FIFO with simultaneous pop and event: nothing dropped
      clear = 1'b1; step(); clear = 1'b0;
      for (int i = 0; i < 16; i++) pulse(16'hB000 + 16'(i));
      check("full_level", RW'(fifo_level), RW'(16));
      sample_valid = 1'b1; sample_data = 16'hBEEF; rec_ready = 1'b1;
      step();
      sample_valid = 1'b0; rec_ready = 1'b0;
      check("full_pp_level", RW'(fifo_level), RW'(16));
      check("full_pp_drops", RW'(drop_count), RW'(0));
      check("full_pp_ovf", RW'(overflow), RW'(0));
      rec_ready = 1'b1;
      repeat (15) step();
      check("full_tail_seq", RW'(rec_data[RW-1:RW-16]), RW'(exp_seq(16)));
      check("full_tail_sample", RW'(rec_data[SW-1:0]), RW'(16'hBEEF));
      step(); rec_ready = 1'b0;
      check("full_drained", RW'(fifo_level), RW'(0));

      // Clear beats a same-cycle event; a level already high does not re-trigger
      sample_valid = 1'b1; sample_data = 16'hC000; clear = 1'b1;
      step();
      clear = 1'b0;
      repeat (2) step();
      check("clr_level", RW'(fifo_level), RW'(0));
      sample_valid = 1'b0; step();
      pulse(16'hC001);
      check("clr_seq", RW'(rec_data[RW-1:RW-16]), RW'(exp_seq(0)));
      rec_ready = 1'b1; step(); rec_ready = 1'b0;

      // Empty FIFO, event with rec_ready high: no pop, level becomes 1
      sample_valid = 1'b1; sample_data = 16'hC002; rec_ready = 1'b1;
      step();
      check("empty_ev_level", RW'(fifo_level), RW'(1));
      sample_valid = 1'b0; step(); rec_ready = 1'b0;

      // log_en low: edge ignored entirely
      log_en = 1'b0;
      pulse(16'hC003);
      check("gate_level", RW'(fifo_level), RW'(0));
      check("gate_drops", RW'(drop_count), RW'(0));
      log_en = 1'b1;
      pulse(16'hC004);
      check("gate_seq", RW'(rec_data[RW-1:RW-16]), RW'(exp_seq(2)));
      rec_ready = 1'b1; step(); rec_ready = 1'b0;

      // Asynchronous reset mid-stream, checked before any clock edge
      for (int i = 0; i < 17; i++) pulse(16'hD000 + 16'(i));
      check("pre_rst_ovf", RW'(overflow), RW'(1));
      #3 rst_n = 1'b0;
      #1;
      check("arst_valid", RW'(rec_valid), RW'(0));
      check("arst_level", RW'(fifo_level), RW'(0));
      check("arst_data", rec_data, RW'(0));
      check("arst_ovf", RW'(overflow), RW'(0));
      check("arst_drops", RW'(drop_count), RW'(0));
      step();
      rst_n = 1'b1;
      pulse(16'hE000);
      check("post_rst_seq", RW'(rec_data[RW-1:RW-16]), RW'(exp_seq(0)));
      repeat (2) step();

      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
